// File: rtl/lcd_display_sequencer.sv
// Purpose: drives the byte-wide LCD write engine through HD44780 init, then a 2x16 screen from a char source; `LCD_AUTO_REFRESH_EN adds a periodic redraw.
// Latency: one byte every 2 + engine time + DELAY_CYCLES cycles; 38 bytes for the first pass, 34 per redraw.
// Backpressure: each byte waits for a fresh Done (low then high) from the engine; redraw requests during a pass collapse into one pending redraw.
module lcd_display_sequencer #(
    parameter logic [17:0] DELAY_CYCLES   = 18'h3FFFE,
    parameter int          REFRESH_CYCLES = 25000000
) (
    input  logic       iCLK,
    input  logic       reset,
    input  logic       iRefresh,
    output logic [4:0] oCHAR_ADDR,
    input  logic [7:0] iCHAR_DATA,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_Start,
    input  logic       iLCD_Done,
    output logic       oBusy,
    output logic       oInitDone
);

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT_LOW, WAIT_HIGH, DELAY} state_t;

    state_t      state;
    logic [5:0]  idx;
    logic        pending;
    logic [17:0] dly_cnt;
    logic        auto_req;
    logic        req;
    logic        is_cmd;
    logic [7:0]  cmd_byte;

    // Step table: command bytes at fixed steps, everything else is a character cell.
    always_comb begin
        is_cmd     = 1'b1;
        cmd_byte   = 8'h00;
        oCHAR_ADDR = 5'd0;
        case (idx)
            6'd0:  cmd_byte = 8'h38;
            6'd1:  cmd_byte = 8'h0C;
            6'd2:  cmd_byte = 8'h01;
            6'd3:  cmd_byte = 8'h06;
            6'd4:  cmd_byte = 8'h80;
            6'd21: cmd_byte = 8'hC0;
            default: begin
                is_cmd = 1'b0;
                if (idx < 6'd21)
                    oCHAR_ADDR = {1'b0, 4'(idx - 6'd5)};
                else
                    oCHAR_ADDR = {1'b1, 4'(idx - 6'd22)};
            end
        endcase
    end

`ifdef LCD_AUTO_REFRESH_EN
    logic [24:0] rfr_cnt;

    always_ff @(posedge iCLK or posedge reset) begin
        if (reset)
            rfr_cnt <= '0;
        else if (state != IDLE)
            rfr_cnt <= '0;
        else if (rfr_cnt != 25'(REFRESH_CYCLES - 1))
            rfr_cnt <= rfr_cnt + 25'd1;
    end

    assign auto_req = (state == IDLE) && (rfr_cnt == 25'(REFRESH_CYCLES - 1));
`else
    assign auto_req = 1'b0;
`endif

    assign req = iRefresh | auto_req;

    always_ff @(posedge iCLK or posedge reset) begin
        if (reset) begin
            state      <= SETUP;
            idx        <= 6'd0;
            pending    <= 1'b0;
            dly_cnt    <= 18'd0;
            oLCD_DATA  <= 8'h00;
            oLCD_RS    <= 1'b0;
            oLCD_Start <= 1'b0;
            oBusy      <= 1'b0;
            oInitDone  <= 1'b0;
        end else begin
            oLCD_Start <= 1'b0;
            if (state != IDLE && req)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (req || pending) begin
                        idx     <= 6'd4;
                        oBusy   <= 1'b1;
                        pending <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    oLCD_DATA  <= is_cmd ? cmd_byte : iCHAR_DATA;
                    oLCD_RS    <= ~is_cmd;
                    oLCD_Start <= 1'b1;
                    oBusy      <= 1'b1;
                    state      <= START;
                end
                START: state <= WAIT_LOW;
                // A Done still high from the previous byte must drop before we look for the rising edge.
                WAIT_LOW: begin
                    if (!iLCD_Done)
                        state <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (iLCD_Done) begin
                        dly_cnt <= 18'd0;
                        state   <= DELAY;
                    end
                end
                DELAY: begin
                    if (dly_cnt == DELAY_CYCLES - 18'd1) begin
                        if (idx == 6'd37) begin
                            oBusy     <= 1'b0;
                            oInitDone <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= SETUP;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + 18'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_display_sequencer.sv
// Directed bench for lcd_display_sequencer with a simple write-engine model (Done falls after Start, rises 18 cycles later).
module tb_lcd_display_sequencer;

    logic       iCLK = 1'b0;
    logic       reset = 1'b1;
    logic       iRefresh = 1'b0;
    logic       iLCD_Done = 1'b1;
    logic [4:0] oCHAR_ADDR;
    logic [7:0] iCHAR_DATA;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS;
    logic       oLCD_Start;
    logic       oBusy;
    logic       oInitDone;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_fall = -1;
    int t_rise = -1;
    int lag = 0;
    int last_start = 0;
    bit dead = 1'b0;

    typedef struct {
        int         step;
        logic       rs;
        logic [7:0] dat;
        logic [4:0] addr;
    } vec_t;

    vec_t vec[38];

    lcd_display_sequencer #(
        .DELAY_CYCLES  (18'd4),
        .REFRESH_CYCLES(100)
    ) dut (
        .iCLK      (iCLK),
        .reset     (reset),
        .iRefresh  (iRefresh),
        .oCHAR_ADDR(oCHAR_ADDR),
        .iCHAR_DATA(iCHAR_DATA),
        .oLCD_DATA (oLCD_DATA),
        .oLCD_RS   (oLCD_RS),
        .oLCD_Start(oLCD_Start),
        .iLCD_Done (iLCD_Done),
        .oBusy     (oBusy),
        .oInitDone (oInitDone)
    );

    always #5 iCLK = ~iCLK;

    // Character source: 'A'+col on the top line, '0'+col on the bottom line.
    assign iCHAR_DATA = oCHAR_ADDR[4] ? (8'h30 + {4'h0, oCHAR_ADDR[3:0]})
                                      : (8'h41 + {4'h0, oCHAR_ADDR[3:0]});

    // Write-engine model; lag delays the falling edge of Done to mimic a stale Done.
    always @(posedge iCLK) begin
        cyc = cyc + 1;
        #1;
        if (oLCD_Start) begin
            t_fall = cyc + lag;
            t_rise = cyc + lag + 18;
        end
        if (cyc == t_fall) iLCD_Done = 1'b0;
        if (cyc == t_rise) iLCD_Done = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic get_start(output logic rs, output logic [7:0] d, output logic [4:0] a, output int gap);
        bit seen = 1'b0;
        rs = 1'b0; d = 8'h00; a = 5'd0; gap = 0;
        for (int i = 0; i < 400 && !seen && !dead; i++) begin
            @(negedge iCLK);
            if (oLCD_Start) begin
                seen = 1'b1;
                rs = oLCD_RS; d = oLCD_DATA; a = oCHAR_ADDR;
                gap = cyc - last_start;
                last_start = cyc;
            end
        end
        if (!seen) begin
            dead = 1'b1;
            n_cmp++;
            n_bad++;
            $display("FAIL start_timeout: no oLCD_Start pulse within budget");
        end
    endtask

    task automatic run_pass(input int first, input string tag);
        logic rs; logic [7:0] d; logic [4:0] a; int gap;
        for (int i = first; i < 38; i++) begin
            get_start(rs, d, a, gap);
            chk($sformatf("%s_step%0d", tag, i), {18'd0, rs, d, a}, {18'd0, vec[i].rs, vec[i].dat, vec[i].addr});
            if (i != first) chk($sformatf("%s_gap%0d", tag, i), gap, 24);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100 && oBusy; i++) @(negedge iCLK);
        chk(tag, oBusy, 1'b0);
    endtask

    task automatic quiet(input int n, input string tag);
        int cnt = 0;
        repeat (n) begin
            @(negedge iCLK);
            if (oLCD_Start) cnt++;
        end
        chk(tag, cnt, 0);
    endtask

    task automatic pulse_refresh();
        @(negedge iCLK);
        iRefresh = 1'b1;
        @(negedge iCLK);
        iRefresh = 1'b0;
    endtask

    initial begin
        logic [7:0] cmds[5];
        logic rs; logic [7:0] d; logic [4:0] a; int gap;

        cmds = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
        for (int i = 0; i < 5; i++) vec[i] = '{i, 1'b0, cmds[i], 5'd0};
        vec[21] = '{21, 1'b0, 8'hC0, 5'd0};
        for (int c = 0; c < 16; c++) begin
            vec[5 + c]  = '{5 + c,  1'b1, 8'h41 + 8'(c), {1'b0, 4'(c)}};
            vec[22 + c] = '{22 + c, 1'b1, 8'h30 + 8'(c), {1'b1, 4'(c)}};
        end

        // Reset state and automatic init pass.
        repeat (3) @(negedge iCLK);
        chk("reset_outputs", {oLCD_DATA, oLCD_RS, oLCD_Start, oBusy, oInitDone, oCHAR_ADDR}, 0);
        reset = 1'b0;
        @(posedge iCLK);
        #1;
        chk("busy_after_release", oBusy, 1'b1);
        chk("initdone_during_init", oInitDone, 1'b0);
        run_pass(0, "init");
        chk("initdone_before_idle", oInitDone, 1'b0);
        wait_idle("init_busy_drop");
        chk("initdone_after_init", oInitDone, 1'b1);
        quiet(50, "idle_after_init");

        // Single redraw skips the init commands.
        pulse_refresh();
        run_pass(4, "redraw");
        wait_idle("redraw_busy_drop");
        chk("initdone_sticky", oInitDone, 1'b1);
        quiet(50, "idle_after_redraw");

        // Three requests during a pass collapse into one extra redraw.
        pulse_refresh();
        for (int i = 4; i < 38; i++) begin
            get_start(rs, d, a, gap);
            chk($sformatf("pend_a_step%0d", i), {18'd0, rs, d, a}, {18'd0, vec[i].rs, vec[i].dat, vec[i].addr});
            if (i == 8 || i == 15 || i == 30) pulse_refresh();
        end
        run_pass(4, "pend_b");
        wait_idle("pend_busy_drop");
        quiet(200, "pend_single_redraw");

        // Stale Done held high across Start must not advance the byte.
        lag = 5;
        pulse_refresh();
        get_start(rs, d, a, gap);
        chk("stale_first_byte", {23'd0, rs, d}, {23'd0, 1'b0, 8'h80});
        get_start(rs, d, a, gap);
        lag = 0;
        chk("stale_done_gap", gap, 29);
        chk("stale_second_byte", {18'd0, rs, d, a}, {18'd0, vec[5].rs, vec[5].dat, vec[5].addr});
        for (int i = 6; i < 9; i++) begin
            get_start(rs, d, a, gap);
            chk($sformatf("pre_rst_step%0d", i), {18'd0, rs, d, a}, {18'd0, vec[i].rs, vec[i].dat, vec[i].addr});
        end

        // Asynchronous reset mid-byte, then init restarts from 0x38.
        #2;
        reset = 1'b1;
        #1;
        chk("midpass_reset_outputs", {oLCD_DATA, oLCD_RS, oLCD_Start, oBusy, oInitDone, oCHAR_ADDR}, 0);
        repeat (3) @(negedge iCLK);
        reset = 1'b0;
        run_pass(0, "reinit");
        wait_idle("reinit_busy_drop");
        chk("initdone_after_reinit", oInitDone, 1'b1);

        // No auto-refresh in the default build.
        quiet(300, "no_auto_refresh");
        chk("idle_not_busy", oBusy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
